// File: rtl/match_window_counter_pkg.sv
// -----------------------------------------------------------------------------
// mwc_pkg
// Shared types and defaults for the match window counter.
//   state_t     : window FSM state (IDLE, COUNT)
//   WINDOW_DEF  : default window length in clock cycles
//   CNT_W_DEF   : default width of the per-window match count
// -----------------------------------------------------------------------------
package mwc_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam int WINDOW_DEF = 16;
    localparam int CNT_W_DEF  = 8;

endpackage : mwc_pkg

// File: rtl/match_window_counter_if.sv
// -----------------------------------------------------------------------------
// match_window_counter_if
// Report channel from the match window counter to its consumer.
//   count_out   : count of the completed window
//   count_sat   : the reported window saturated
//   count_valid : a report is pending
//   count_ready : consumer accepts the report
// Modports: master (counter side), slave (consumer side).
// -----------------------------------------------------------------------------
interface match_window_counter_if
    import mwc_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);

    logic [CNT_W-1:0] count_out;
    logic             count_sat;
    logic             count_valid;
    logic             count_ready;

    modport master (
        output count_out,
        output count_sat,
        output count_valid,
        input  count_ready
    );

    modport slave (
        input  count_out,
        input  count_sat,
        input  count_valid,
        output count_ready
    );

endinterface : match_window_counter_if

// File: rtl/match_window_counter_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear.
//   clk    : clock
//   rst    : synchronous active-high reset
//   clr_i  : synchronous clear (takes priority over increment)
//   inc_i  : increment request
//   next_o : value after this cycle's increment, saturating (before clear)
//   sat_o  : counter currently holds its maximum value
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] next_o,
    output logic         sat_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign sat_o = &cnt_q;

    always_comb begin
        // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
        cnt_d = cnt_q;
        if (inc_i && !sat_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    assign next_o = cnt_d;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst || clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : sat_counter

// File: rtl/match_window_counter.sv
// -----------------------------------------------------------------------------
// match_window_counter
// Counts one-cycle match pulses over fixed windows of WINDOW cycles and
// publishes each window's count through a depth-1 valid/ready report register.
//   clk        : clock
//   rst        : synchronous active-high reset
//   enable_i   : run windows while high
//   match_in_i : detector pulse, one match per high cycle
//   drop_o     : one-cycle pulse, a completed window was discarded
//   rpt        : report channel (count_out, count_sat, count_valid, count_ready)
// -----------------------------------------------------------------------------
module match_window_counter
    import mwc_pkg::*;
#(
    parameter int WINDOW = WINDOW_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable_i,
    input  logic                   match_in_i,
    output logic                   drop_o,
    match_window_counter_if.master rpt
);

    localparam int              WIN_W    = $clog2(WINDOW);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

    state_t           state_q;
    logic [WIN_W-1:0] win_cnt_q;
    logic             sat_flag_q;
    logic [CNT_W-1:0] count_q;
    logic             count_sat_q;
    logic             count_valid_q;
    logic             drop_q;

    logic             counting;
    logic             win_end;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             cnt_at_max;
    logic [CNT_W-1:0] final_cnt;
    logic             final_sat;
    logic             transfer;
    logic             can_load;

    // A cycle belongs to a window only while in COUNT with enable still high;
    // enable low in COUNT discards the partial window instead.
    assign counting = (state_q == COUNT) && enable_i;
    assign win_end  = counting && (win_cnt_q == WIN_LAST);
    assign cnt_inc  = counting && match_in_i;
    assign cnt_clr  = !counting || win_end;

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .next_o (final_cnt),
        .sat_o  (cnt_at_max)
    );

    // A last-cycle match that hits an already-full counter also saturates the report.
    assign final_sat = sat_flag_q || (cnt_inc && cnt_at_max);

    assign transfer = count_valid_q && rpt.count_ready;
    // The slot is free if empty or being emptied by a transfer this cycle.
    assign can_load = !count_valid_q || rpt.count_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            win_cnt_q     <= '0;
            sat_flag_q    <= 1'b0;
            count_q       <= '0;
            count_sat_q   <= 1'b0;
            count_valid_q <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            drop_q <= 1'b0;
            if (transfer) begin
                count_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (enable_i) begin
                        state_q <= COUNT;
                    end
                end
                COUNT: begin
                    if (!enable_i) begin
                        state_q    <= IDLE;
                        win_cnt_q  <= '0;
                        sat_flag_q <= 1'b0;
                    end else if (win_end) begin
                        win_cnt_q  <= '0;
                        sat_flag_q <= 1'b0;
                        if (can_load) begin
                            count_q       <= final_cnt;
                            count_sat_q   <= final_sat;
                            count_valid_q <= 1'b1;
                        end else begin
                            drop_q <= 1'b1;
                        end
                    end else begin
                        win_cnt_q <= win_cnt_q + WIN_W'(1);
                        if (cnt_inc && cnt_at_max) begin
                            sat_flag_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rpt.count_out   = count_q;
    assign rpt.count_sat   = count_sat_q;
    assign rpt.count_valid = count_valid_q;
    assign drop_o          = drop_q;

endmodule : match_window_counter
